// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core data port and data memory, with load forwarding.
// Optional feature: define DMEM_STBUF_FWD_EN for byte-accurate store-to-load forwarding.
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [3:0]  byteEnable,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // Write channel: mem_wvalid means the head entry is valid; a transfer happens on
  // any rising edge where mem_wvalid && mem_wready. Once raised, mem_wvalid and
  // mem_w* hold steady until that transfer (or until reset discards the buffer).

  logic [29:0]   addr_q [DEPTH];
  logic [29:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [3:0]    strb_q [DEPTH];
  logic [3:0]    strb_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic full;
  logic enq;
  logic deq;
  logic stall_full;
  logic unused_addr_lsbs;

  assign full       = (count_q == CW'(DEPTH));
  assign enq        = MemWrite && (byteEnable != 4'b0000) && !full;
  assign deq        = mem_wvalid && mem_wready;
  assign stall_full = MemWrite && full;

  assign mem_raddr        = {ALUResult[31:2], 2'b00};
  assign unused_addr_lsbs = ^ALUResult[1:0];

  assign mem_wvalid = (count_q != '0);
  assign mem_waddr  = {addr_q[head_q], 2'b00};
  assign mem_wdata  = data_q[head_q];
  assign mem_wstrb  = strb_q[head_q];

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      addr_d[tail_q] = ALUResult[31:2];
      data_d[tail_q] = WriteData;
      strb_d[tail_q] = byteEnable;
      tail_d         = tail_q + AW'(1);
    end
    if (deq) begin
      head_d = head_q + AW'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef DMEM_STBUF_FWD_EN
  logic [31:0] rdata_fwd;
  logic        unused_mem_read;

  assign unused_mem_read = MemRead;

  // Walk oldest to youngest so a younger matching lane overwrites an older one.
  always_comb begin
    logic [AW-1:0] idx;
    rdata_fwd = mem_rdata;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == ALUResult[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (strb_q[idx][b]) begin
            rdata_fwd[8*b +: 8] = data_q[idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign ReadData = rdata_fwd;
  assign Stall    = stall_full;
`else
  logic load_hazard;

  // Without forwarding a load must wait until every matching pending store drains.
  always_comb begin
    logic [AW-1:0] idx;
    load_hazard = 1'b0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == ALUResult[31:2])) begin
        load_hazard = 1'b1;
      end
    end
  end

  assign ReadData = mem_rdata;
  assign Stall    = stall_full || (MemRead && load_hazard);
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: expected memory writes are queued at issue
// and checked by an independent write-channel monitor.
module tb_dmem_store_buffer;

  logic        clk;
  logic        rst;
  logic        MemWrite;
  logic        MemRead;
  logic [3:0]  byteEnable;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  logic wready_drv;
  logic rand_wready;
  logic rand_en;

  int n_cmp;
  int n_mis;

  logic [67:0] exp_q[$];

  assign mem_wready = rand_en ? rand_wready : wready_drv;

  dmem_store_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (rst),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .byteEnable (byteEnable),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    n_mis++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "timeout");
  end

  initial begin
    rand_wready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) rand_wready = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the store.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    logic st;
    bit   done;
    done       = 1'b0;
    MemWrite   = 1'b1;
    ALUResult  = addr;
    WriteData  = data;
    byteEnable = be;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      st = Stall;
      @(posedge clk);
      #1;
      if (!st) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_mis++;
      $display("FAIL store_accept_timeout: got stalled expected accepted addr %h", addr);
    end else if (be != 4'b0000) begin
      exp_q.push_back({addr[31:2], 2'b00, data, be});
    end
    MemWrite   = 1'b0;
    byteEnable = 4'b0000;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_wvalid_low", {31'd0, mem_wvalid}, 32'd0);
  endtask

  // scoreboard monitor: handshakes are decided on the next rising edge
  initial begin
    logic [67:0] got;
    logic [67:0] want;
    logic [67:0] held;
    bit          holding;
    holding = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      got = {mem_waddr, mem_wdata, mem_wstrb};
      if (rst) begin
        holding = 1'b0;
      end else begin
        if (holding) begin
          n_cmp++;
          if (!mem_wvalid || got !== held) begin
            n_mis++;
            $display("FAIL wchan_stable: got v=%b %h expected v=1 %h", mem_wvalid, got, held);
          end
        end
        holding = 1'b0;
        if (mem_wvalid && mem_wready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL wchan_unexpected: got %h expected no write", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              n_mis++;
              $display("FAIL wchan_write: got addr %h data %h strb %h expected addr %h data %h strb %h",
                       got[67:36], got[35:4], got[3:0], want[67:36], want[35:4], want[3:0]);
            end
          end
        end else if (mem_wvalid) begin
          holding = 1'b1;
          held    = got;
        end
      end
    end
  end

  logic [31:0] wa_addr [12];
  logic [31:0] wa_data [12];
  logic [3:0]  wa_be   [12];

  initial begin
    n_cmp      = 0;
    n_mis      = 0;
    rst        = 1'b1;
    rand_en    = 1'b0;
    wready_drv = 1'b0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    byteEnable = 4'b0000;
    ALUResult  = 32'h0000_1237;
    WriteData  = 32'd0;
    mem_rdata  = 32'hCAFE_F00D;

    // reset state
    #1;
    check("rst_wvalid", {31'd0, mem_wvalid}, 32'd0);
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_readdata", ReadData, 32'hCAFE_F00D);
    check("raddr_align", mem_raddr, 32'h0000_1234);
    #11;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single store then drain
    wready_drv = 1'b1;
    do_store(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    check("single_wvalid", {31'd0, mem_wvalid}, 32'd1);
    check("single_waddr", mem_waddr, 32'h0000_1000);
    check("single_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("single_wstrb", {28'd0, mem_wstrb}, 32'hF);
    @(posedge clk);
    #1;
    check("single_retired", {31'd0, mem_wvalid}, 32'd0);

    // fill and stall
    wready_drv = 1'b0;
    do_store(32'h0000_0100, 32'h0000_0001, 4'hF);
    do_store(32'h0000_0104, 32'h0000_0002, 4'h3);
    do_store(32'h0000_0108, 32'h0000_0003, 4'hC);
    do_store(32'h0000_010C, 32'h0000_0004, 4'h1);
    MemWrite   = 1'b1;
    ALUResult  = 32'h0000_0110;
    WriteData  = 32'h0000_0005;
    byteEnable = 4'hF;
    #1;
    check("full_stall", {31'd0, Stall}, 32'd1);
    wready_drv = 1'b1;
    #1;
    check("stall_during_deq", {31'd0, Stall}, 32'd1);
    @(posedge clk);
    #1;
    wready_drv = 1'b0;
    check("stall_lifted", {31'd0, Stall}, 32'd0);
    @(posedge clk);
    #1;
    exp_q.push_back({32'h0000_0110, 32'h0000_0005, 4'hF});
    MemWrite   = 1'b0;
    byteEnable = 4'h0;
    wready_drv = 1'b1;
    wait_drain();

    // byte forwarding / load hazard
    wready_drv = 1'b0;
    mem_rdata  = 32'h1122_3344;
    do_store(32'h0000_2000, 32'h0000_AABB, 4'b0011);
    do_store(32'h0000_2000, 32'h00CC_DD00, 4'b0110);
    do_store(32'h0000_3000, 32'h5566_7788, 4'b1111);
    MemRead   = 1'b1;
    ALUResult = 32'h0000_2002;
    #1;
    check("load_raddr", mem_raddr, 32'h0000_2000);
`ifdef DMEM_STBUF_FWD_EN
    check("fwd_two_entries", ReadData, 32'h11CC_DDBB);
    check("fwd_no_stall", {31'd0, Stall}, 32'd0);
`else
    check("nofwd_stall_two", {31'd0, Stall}, 32'd1);
    check("nofwd_readdata", ReadData, 32'h1122_3344);
`endif
    wready_drv = 1'b1;
    @(posedge clk);
    #1;
`ifdef DMEM_STBUF_FWD_EN
    check("fwd_one_entry", ReadData, 32'h11CC_DD44);
`else
    check("nofwd_stall_one", {31'd0, Stall}, 32'd1);
`endif
    @(posedge clk);
    #1;
    check("load_after_drain_stall", {31'd0, Stall}, 32'd0);
    check("load_after_drain_data", ReadData, 32'h1122_3344);
    MemRead = 1'b0;
    wait_drain();

    // reset mid-operation
    wready_drv = 1'b0;
    do_store(32'h0000_7000, 32'h7000_0000, 4'hF);
    do_store(32'h0000_7004, 32'h7000_0004, 4'hF);
    do_store(32'h0000_7008, 32'h7000_0008, 4'hF);
    do_store(32'h0000_700C, 32'h7000_000C, 4'hF);
    MemWrite   = 1'b1;
    ALUResult  = 32'h0000_7100;
    byteEnable = 4'hF;
    #1;
    check("pre_rst_stall", {31'd0, Stall}, 32'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    wready_drv = 1'b1;
    #1;
    check("rst_mid_wvalid", {31'd0, mem_wvalid}, 32'd0);
    check("rst_mid_stall", {31'd0, Stall}, 32'd0);
    MemWrite   = 1'b0;
    byteEnable = 4'h0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_empty", {31'd0, mem_wvalid}, 32'd0);
    do_store(32'h0000_8000, 32'h0BAD_CAFE, 4'hF);
    check("post_rst_head", mem_waddr, 32'h0000_8000);
    wait_drain();

    // wrap-around with random ready, including byteEnable==0 stores
    wa_addr = '{32'h6000, 32'h6007, 32'h6008, 32'h600C, 32'h6010, 32'h6010,
                32'h6021, 32'h6024, 32'h6028, 32'h602C, 32'h6030, 32'h6034};
    wa_data = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004,
                32'hE4E4_0005, 32'hF5F5_0006, 32'h0606_0007, 32'h1717_0008,
                32'h2828_0009, 32'h3939_000A, 32'h4A4A_000B, 32'h5B5B_000C};
    wa_be   = '{4'hF, 4'h1, 4'h0, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h0, 4'h6, 4'h9, 4'hF};
    rand_en = 1'b1;
    for (int i = 0; i < 12; i++) do_store(wa_addr[i], wa_data[i], wa_be[i]);
    check("wrap_queued", 32'(exp_q.size()) <= 32'd4 ? 32'd1 : 32'd0, 32'd1);
    rand_en    = 1'b0;
    wready_drv = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
